// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared widths, writeback select encoding and NZP helper for the LC3 writeback stage
package writeback_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 3;

    typedef enum logic [1:0] {
        WB_ALU = 2'b00,
        WB_MEM = 2'b01,
        WB_PC  = 2'b10,
        WB_NPC = 2'b11
    } wb_sel_t;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    // Sign bit wins over the zero test so 16'h8000 reports negative.
    function automatic logic [2:0] nzp(input logic [DATA_W-1:0] x);
        logic [2:0] cc;
        if (x[DATA_W-1]) begin
            cc = NZP_N;
        end else if (x == '0) begin
            cc = NZP_Z;
        end else begin
            cc = NZP_P;
        end
        return cc;
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - general register file, one write port and two combinational read ports
module lc3_regfile
    import writeback_pkg::*;
#(
    parameter int DW = DATA_W,
    parameter int AW = REG_ADDR_W
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr1_i,
    input  logic [AW-1:0] raddr2_i,
    output logic [DW-1:0] rdata1_o,
    output logic [DW-1:0] rdata2_o
);

    localparam int NREGS = 1 << AW;

    logic [DW-1:0] regs_q [NREGS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    // Reads come straight from storage: a register being written shows its old value until the edge.
    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/lc3_writeback_unit.sv
// rtl/lc3_writeback_unit.sv - LC3 writeback: result select, register file commit and NZP condition code
module lc3_writeback_unit
    import writeback_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_writeback,
    input  logic [DATA_W-1:0]     aluout,
    input  logic [DATA_W-1:0]     memout,
    input  logic [DATA_W-1:0]     pcout,
    input  logic [DATA_W-1:0]     npc,
    input  logic [REG_ADDR_W-1:0] sr1,
    input  logic [REG_ADDR_W-1:0] sr2,
    input  logic [REG_ADDR_W-1:0] dr,
    input  logic [1:0]            W_control,
    output logic [DATA_W-1:0]     VSR1,
    output logic [DATA_W-1:0]     VSR2,
    output logic [2:0]            psr
);

    wb_sel_t           wb_sel;
    logic [DATA_W-1:0] dr_in;
    logic [2:0]        psr_q;
    logic [2:0]        psr_d;

    assign wb_sel = wb_sel_t'(W_control);

    always_comb begin
        dr_in = aluout;
        unique case (wb_sel)
            WB_ALU: dr_in = aluout;
            WB_MEM: dr_in = memout;
            WB_PC:  dr_in = pcout;
            WB_NPC: dr_in = npc;
            default: dr_in = aluout;
        endcase
    end

    assign psr_d = enable_writeback ? nzp(dr_in) : psr_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            psr_q <= 3'b000;
        end else begin
            psr_q <= psr_d;
        end
    end

    assign psr = psr_q;

    lc3_regfile #(
        .DW(DATA_W),
        .AW(REG_ADDR_W)
    ) u_regfile (
        .clk_i    (clock),
        .rst_n_i  (reset),
        .we_i     (enable_writeback),
        .waddr_i  (dr),
        .wdata_i  (dr_in),
        .raddr1_i (sr1),
        .raddr2_i (sr2),
        .rdata1_o (VSR1),
        .rdata2_o (VSR2)
    );

endmodule
